// File: rtl/mem_read_unit.sv
// rtl/mem_read_unit.sv - sequential load path: one read strobe, fixed latency, extract and extend
module mem_read_unit #(
    parameter  int DATA_W = 32,
    parameter  int LAT    = 2,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [OFF_W-1:0]  offset,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] data_out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [2:0] M_LW  = 3'b000;
    localparam logic [2:0] M_LH  = 3'b001;
    localparam logic [2:0] M_LHU = 3'b010;
    localparam logic [2:0] M_LB  = 3'b011;
    localparam logic [2:0] M_LBU = 3'b100;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [2:0]          mode_q, mode_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic                mem_rd_q, mem_rd_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic                illegal;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   ext;

    always_comb begin
        illegal = (mode > M_LBU)
               || (((mode == M_LH) || (mode == M_LHU)) && offset[0])
               || ((mode == M_LW) && (offset != '0));
    end

    // Little-endian: the addressed field lands in the low bits after shifting by 8*offset.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (mode_q)
            M_LH:    ext = DATA_W'($signed(shifted[15:0]));
            M_LHU:   ext = DATA_W'(shifted[15:0]);
            M_LB:    ext = DATA_W'($signed(shifted[7:0]));
            M_LBU:   ext = DATA_W'(shifted[7:0]);
            default: ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        off_d    = off_q;
        mem_rd_d = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (illegal) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        data_d  = '0;
                    end else begin
                        state_d  = S_WAIT;
                        mode_d   = mode;
                        off_d    = offset;
                        cnt_d    = 4'(LAT - 1);
                        mem_rd_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    data_d  = ext;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            mode_q   <= 3'b000;
            off_q    <= '0;
            mem_rd_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            off_q    <= off_d;
            mem_rd_q <= mem_rd_d;
            done_q   <= done_d;
            err_q    <= err_d;
            data_q   <= data_d;
        end
    end

    assign mem_rd   = mem_rd_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign data_out = data_q;

endmodule

// File: tb/tb_mem_read_unit.sv
// tb/tb_mem_read_unit.sv - directed vector bench for mem_read_unit at three parameter points
`timescale 1ns/1ps
module tb_mem_read_unit;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // DUT0: DATA_W=32, LAT=2
    logic        start0 = 1'b0;
    logic [2:0]  mode0 = 3'b000;
    logic [1:0]  off0 = 2'd0;
    logic [31:0] rdata0 = 32'h8081F27F;
    logic        mem_rd0, busy0, done0, err0;
    logic [31:0] dout0;

    // DUT1: DATA_W=64, LAT=1 ; DUT2: DATA_W=64, LAT=15
    logic        start64 [2];
    logic [2:0]  mode64  [2];
    logic [2:0]  off64   [2];
    logic [63:0] rdata64 [2];
    logic        mem_rd64[2], busy64[2], done64[2], err64[2];
    logic [63:0] dout64  [2];

    int n_pass = 0;
    int n_total = 0;

    mem_read_unit #(.DATA_W(32), .LAT(2)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .mode(mode0), .offset(off0),
        .mem_rd(mem_rd0), .mem_rdata(rdata0), .busy(busy0), .done(done0),
        .err(err0), .data_out(dout0)
    );

    mem_read_unit #(.DATA_W(64), .LAT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start64[0]), .mode(mode64[0]), .offset(off64[0]),
        .mem_rd(mem_rd64[0]), .mem_rdata(rdata64[0]), .busy(busy64[0]), .done(done64[0]),
        .err(err64[0]), .data_out(dout64[0])
    );

    mem_read_unit #(.DATA_W(64), .LAT(15)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start64[1]), .mode(mode64[1]), .offset(off64[1]),
        .mem_rd(mem_rd64[1]), .mem_rdata(rdata64[1]), .busy(busy64[1]), .done(done64[1]),
        .err(err64[1]), .data_out(dout64[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One request on DUT0; poke=1 also pulses start mid-WAIT with other mode/offset and in the DONE cycle.
    task automatic run32(input string nm, input logic [2:0] m, input logic [1:0] o,
                         input logic [31:0] exp_d, input logic exp_e, input int exp_lat, input bit poke);
        int k;
        int rd_cnt;
        bit seen;
        @(negedge clk);
        start0 = 1'b1; mode0 = m; off0 = o;
        @(negedge clk);
        start0 = 1'b0;
        k = 0; rd_cnt = 0; seen = 1'b0;
        while (k < 40 && !seen) begin
            if (mem_rd0) rd_cnt++;
            if (done0) seen = 1'b1;
            else begin
                if (poke && k == 0) begin start0 = 1'b1; mode0 = 3'b011; off0 = 2'd1; end
                else start0 = 1'b0;
                @(negedge clk);
                k++;
            end
        end
        chk({nm, " latency"}, seen ? 64'(k) : 64'hFFFF, 64'(exp_lat));
        chk({nm, " mem_rd count"}, 64'(rd_cnt), (exp_lat > 0) ? 64'd1 : 64'd0);
        chk({nm, " data_out"}, 64'(dout0), 64'(exp_d));
        chk({nm, " err"}, 64'(err0), 64'(exp_e));
        if (poke) start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk({nm, " done one cycle"}, 64'(done0), 64'd0);
        if (poke) chk({nm, " start in DONE ignored"}, 64'(busy0), 64'd0);
    endtask

    task automatic run64(input string nm, input int d, input logic [2:0] m, input logic [2:0] o,
                         input logic [63:0] rd, input logic [63:0] exp_d, input int exp_lat);
        int k;
        bit seen;
        @(negedge clk);
        start64[d] = 1'b1; mode64[d] = m; off64[d] = o; rdata64[d] = rd;
        @(negedge clk);
        start64[d] = 1'b0;
        k = 0; seen = 1'b0;
        while (k < 40 && !seen) begin
            if (done64[d]) seen = 1'b1;
            else begin @(negedge clk); k++; end
        end
        chk({nm, " latency"}, seen ? 64'(k) : 64'hFFFF, 64'(exp_lat));
        chk({nm, " data_out"}, dout64[d], exp_d);
        chk({nm, " err"}, 64'(err64[d]), 64'd0);
    endtask

    // Hold start high and check the spacing between successive read strobes.
    task automatic b2b(input string nm, input int d, input int lat);
        int hits[$];
        @(negedge clk);
        start64[d] = 1'b1; mode64[d] = 3'b100; off64[d] = 3'd0;
        for (int c = 0; c < 3 * (lat + 2) + 2; c++) begin
            @(negedge clk);
            if (mem_rd64[d]) hits.push_back(c);
        end
        start64[d] = 1'b0;
        chk({nm, " strobe count"}, 64'(hits.size() >= 3), 64'd1);
        for (int i = 1; i < 3 && i < hits.size(); i++)
            chk({nm, " interval"}, 64'(hits[i] - hits[i-1]), 64'(lat + 2));
        repeat (lat + 4) @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  m;
        logic [1:0]  o;
        logic [31:0] d;
        logic        e;
        int          lat;
    } vec_t;

    vec_t tbl[13];
    int   rst_dones;

    initial begin
        for (int i = 0; i < 2; i++) begin
            start64[i] = 1'b0; mode64[i] = 3'b000; off64[i] = 3'd0; rdata64[i] = 64'd0;
        end
        tbl[0]  = '{3'b000, 2'd0, 32'h8081F27F, 1'b0, 2};
        tbl[1]  = '{3'b011, 2'd1, 32'hFFFFFFF2, 1'b0, 2};
        tbl[2]  = '{3'b100, 2'd1, 32'h000000F2, 1'b0, 2};
        tbl[3]  = '{3'b011, 2'd0, 32'h0000007F, 1'b0, 2};
        tbl[4]  = '{3'b100, 2'd3, 32'h00000080, 1'b0, 2};
        tbl[5]  = '{3'b001, 2'd2, 32'hFFFF8081, 1'b0, 2};
        tbl[6]  = '{3'b001, 2'd1, 32'h00000000, 1'b1, 0};
        tbl[7]  = '{3'b010, 2'd2, 32'h00008081, 1'b0, 2};
        tbl[8]  = '{3'b000, 2'd2, 32'h00000000, 1'b1, 0};
        tbl[9]  = '{3'b001, 2'd0, 32'hFFFFF27F, 1'b0, 2};
        tbl[10] = '{3'b110, 2'd0, 32'h00000000, 1'b1, 0};
        tbl[11] = '{3'b011, 2'd3, 32'hFFFFFF80, 1'b0, 2};
        tbl[12] = '{3'b010, 2'd3, 32'h00000000, 1'b1, 0};

        repeat (3) @(negedge clk);
        chk("reset mem_rd", 64'(mem_rd0), 64'd0);
        chk("reset busy", 64'(busy0), 64'd0);
        chk("reset done", 64'(done0), 64'd0);
        chk("reset err", 64'(err0), 64'd0);
        chk("reset data_out", 64'(dout0), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run32("LW busy-poke", 3'b000, 2'd0, 32'h8081F27F, 1'b0, 2, 1'b1);
        repeat (6) @(negedge clk);
        chk("no queued request", 64'(busy0), 64'd0);

        for (int i = 0; i < 13; i++)
            run32($sformatf("vec%0d", i), tbl[i].m, tbl[i].o, tbl[i].d, tbl[i].e, tbl[i].lat, 1'b0);

        run64("LAT1 LB off7", 0, 3'b011, 3'd7, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFF80, 1);
        run64("LAT15 LB off7", 1, 3'b011, 3'd7, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFF80, 15);
        run64("LAT1 LHU off6", 0, 3'b010, 3'd6, 64'h1234ABCD_00000000, 64'h00000000_00001234, 1);
        b2b("LAT1 b2b", 0, 1);
        b2b("LAT15 b2b", 1, 15);

        // Reset while DUT2 is in its first WAIT cycle with the strobe up.
        @(negedge clk);
        start64[1] = 1'b1; mode64[1] = 3'b000; off64[1] = 3'd0; rdata64[1] = 64'h5555;
        @(negedge clk);
        start64[1] = 1'b0;
        chk("pre-reset mem_rd", 64'(mem_rd64[1]), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset mem_rd", 64'(mem_rd64[1]), 64'd0);
        chk("async reset busy", 64'(busy64[1]), 64'd0);
        chk("async reset data_out", dout64[1], 64'd0);
        chk("async reset err", 64'(err64[1]), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rst_dones = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done64[1] || busy64[1]) rst_dones++;
        end
        chk("no done after reset", 64'(rst_dones), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_read_unit.md
# mem_read_unit

Parametrised, sequential successor to the combinational load-path select. It accepts one load request from the control unit and issues a single memory read strobe. It waits a fixed, parametrised memory latency, then captures the returned word. It extracts and sign/zero-extends the addressed byte, halfword or word, and holds the result on a registered output for the MDR/write-back path. Misaligned and undefined requests are flagged without touching memory.

## Interface
- DATA_W, 32: memory word width in bits; multiple of 16, ≥ 16.
- LAT, 2: memory read latency in cycles, 1..15; data is valid LAT cycles after the strobe.
- OFF_W, $clog2(DATA_W/8): byte-offset width (derived, not overridden).
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; honoured only while busy = 0.
- mode  in  3  load type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101/110/111 undefined.
- offset  in  OFF_W  byte address within the word, little-endian: byte k = bits [8k+7:8k].
- mem_rd  out  1  memory read strobe, one cycle per accepted legal request.
- mem_rdata  in  DATA_W  word returned by memory.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  set with done when the request was misaligned or undefined; held until next done.
- data_out  out  DATA_W  extended load result; held until next done.

## Operation
- States: IDLE, WAIT, DONE. busy = (state != IDLE).
- IDLE, start = 1, legal request: latch mode/offset, load counter with LAT-1, go to WAIT.
- IDLE, start = 1, illegal request: go to DONE with err = 1 and data_out = 0.
  - Illegal means mode 101–111, LH/LHU with offset[0] = 1, or LW with offset ≠ 0.
  - mem_rd is never asserted for an illegal request.
- WAIT: mem_rd = 1 in the first WAIT cycle only.
  - Counter decrements each cycle.
  - When counter = 0, capture mem_rdata on that edge, compute the result, go to DONE.
- Extraction:
  - LW: the whole word.
  - LH/LHU: halfword at offset (bits [8·off+15 : 8·off]).
  - LB/LBU: byte at offset.
- Extension:
  - LH and LB sign-extend from the top bit of the field to DATA_W.
  - LHU and LBU zero-extend.
- DONE: done = 1 for exactly one cycle. data_out and err update on entry to DONE. Next state is IDLE.
- start while busy = 1 is ignored: not queued, no effect on the in-flight request.
- mode/offset changes after acceptance have no effect (latched values are used).
- Reset, including mid-WAIT: the in-flight request is abandoned and no done is produced.

## Timing
- Reset values: state IDLE, mem_rd 0, busy 0, done 0, err 0, data_out 0, counter 0.
- All outputs are registered; none depend combinationally on inputs.
- Legal request: start sampled high at edge E0.
  - mem_rd high in cycle E0..E1.
  - mem_rdata sampled at edge E(LAT).
  - done high in cycle E(LAT)..E(LAT+1).
  - Load latency is LAT+1 cycles start-to-done; throughput is one request per LAT+2 cycles.
- Illegal request: done and err high in the cycle after the start edge (latency 1); no mem_rd.
- LAT = 1: WAIT lasts one cycle; the mem_rd cycle is also the capture cycle.
- A start asserted in the DONE cycle is ignored. The earliest next acceptance is the following (IDLE) cycle.

## Test plan
- Reset: hold reset_n = 0 mid-WAIT with mem_rd pending → all outputs return to 0 immediately. After release, no done pulse occurs.
- LW, mem_rdata = 0x8081F27F, LAT = 2, offset 0:
  - mem_rd for exactly one cycle.
  - done three cycles after the start edge.
  - data_out = 0x8081F27F, err = 0.
  - start pulsed during busy has no effect.
- Byte loads on word 0x8081F27F:
  - LB offset 1 → 0xFFFFFFF2.
  - LBU offset 1 → 0x000000F2.
  - LB offset 0 → 0x0000007F.
  - LBU offset 3 → 0x00000080.
- Halfword loads on word 0x8081F27F:
  - LH offset 2 → 0xFFFF8081.
  - LHU offset 2 → 0x00008081.
  - LH offset 0 → 0xFFFFF27F.
- Illegal requests each give done plus err one cycle after start, data_out = 0, and mem_rd never high:
  - LH offset 1.
  - LW offset 2.
  - mode 110.
- Parameter sweep: LAT = 1 and LAT = 15, DATA_W = 64.
  - Done timing matches LAT+1.
  - LB offset 7 on 0x80000000_00000000 → 0xFFFFFFFF_FFFFFF80.
  - Back-to-back requests are accepted every LAT+2 cycles.
